// File: rtl/div_sched.sv
// div_sched: sequenced radix-2 restoring divider shared by div.w, mod.w,
// div.wu and mod.wu. One op is in flight at a time; issue and result use
// separate valid/ready handshakes, and cancel aborts the op in flight.
// Optional build macro: DIV_EARLY_OUT_EN skips the iteration phase when
// |dividend| < |divisor|.
`timescale 1ns/1ps
module div_sched #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_src1,
  input  logic [WIDTH-1:0] in_src2,
  input  logic             cancel,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_div_zero
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_CALC = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  // Two's complement negate.
  function automatic logic [WIDTH-1:0] neg_f(input logic [WIDTH-1:0] v);
    neg_f = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Magnitude of a possibly signed operand; the most negative value maps to itself.
  function automatic logic [WIDTH-1:0] abs_f(input logic [WIDTH-1:0] v,
                                             input logic is_signed);
    if (is_signed && v[WIDTH-1]) begin
      abs_f = neg_f(v);
    end else begin
      abs_f = v;
    end
  endfunction

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [1:0]         op_q;          // bit0: remainder wanted, bit1: unsigned
  logic [WIDTH-1:0]   src1_q;
  logic [WIDTH-1:0]   src2_q;
  logic               quo_neg_q;
  logic               rem_neg_q;
  logic [WIDTH-1:0]   dvd_q;         // dividend shifts out, quotient shifts in
  logic [WIDTH-1:0]   rem_q;         // always < divisor, so WIDTH bits suffice
  logic [WIDTH-1:0]   dsr_q;
  logic [WIDTH-1:0]   result_q;
  logic               div_zero_q;
  logic               in_ready_q;
  logic               busy_q;
  logic               out_valid_q;

  logic               accept_s;
  logic [WIDTH-1:0]   abs1_s;
  logic [WIDTH-1:0]   abs2_s;
  logic               div_zero_s;
  logic               early_s;
  logic               last_s;
  logic [WIDTH:0]     rem_sh_s;
  logic [WIDTH:0]     trial_s;
  logic [WIDTH-1:0]   quo_fix_s;
  logic [WIDTH-1:0]   rem_fix_s;
  logic [WIDTH-1:0]   result_d;

  assign accept_s   = in_valid && (state_q == S_IDLE) && !cancel;
  assign abs1_s     = abs_f(src1_q, !op_q[1]);
  assign abs2_s     = abs_f(src2_q, !op_q[1]);
  assign div_zero_s = (src2_q == {WIDTH{1'b0}});
  assign last_s     = (cnt_q == CNT_W'(WIDTH-1));
  // The shifted partial remainder needs one extra bit before the trial subtract.
  assign rem_sh_s   = {rem_q, dvd_q[WIDTH-1]};
  assign trial_s    = rem_sh_s - {1'b0, dsr_q};
  assign quo_fix_s  = quo_neg_q ? neg_f(dvd_q) : dvd_q;
  assign rem_fix_s  = rem_neg_q ? neg_f(rem_q) : rem_q;

`ifdef DIV_EARLY_OUT_EN
  assign early_s = !div_zero_s && (abs1_s < abs2_s);
`else
  assign early_s = 1'b0;
`endif

  // Final result selection, including the zero-divisor convention.
  always_comb begin
    result_d = {WIDTH{1'b0}};
    if (div_zero_s) begin
      if (op_q[0]) begin
        result_d = src1_q;
      end else begin
        result_d = {WIDTH{1'b1}};
      end
    end else begin
      if (op_q[0]) begin
        result_d = rem_fix_s;
      end else begin
        result_d = quo_fix_s;
      end
    end
  end

  // Next-state logic; cancel wins in every busy state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d = S_PREP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PREP: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else if (div_zero_s || early_s) begin
          state_d = S_FIX;
        end else begin
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else if (last_s) begin
          state_d = S_FIX;
        end else begin
          state_d = S_CALC;
        end
      end
      S_FIX: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (cancel || out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Controller state, datapath registers and registered handshake outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      op_q        <= 2'b00;
      src1_q      <= {WIDTH{1'b0}};
      src2_q      <= {WIDTH{1'b0}};
      quo_neg_q   <= 1'b0;
      rem_neg_q   <= 1'b0;
      dvd_q       <= {WIDTH{1'b0}};
      rem_q       <= {WIDTH{1'b0}};
      dsr_q       <= {WIDTH{1'b0}};
      result_q    <= {WIDTH{1'b0}};
      div_zero_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d == S_IDLE);
      busy_q      <= (state_d != S_IDLE);
      out_valid_q <= (state_d == S_DONE);
      case (state_q)
        S_IDLE: begin
          if (accept_s) begin
            op_q       <= in_op;
            src1_q     <= in_src1;
            src2_q     <= in_src2;
            quo_neg_q  <= !in_op[1] && (in_src1[WIDTH-1] ^ in_src2[WIDTH-1]);
            rem_neg_q  <= !in_op[1] && in_src1[WIDTH-1];
            result_q   <= {WIDTH{1'b0}};
            div_zero_q <= 1'b0;
          end else begin
            op_q <= op_q;
          end
        end
        S_PREP: begin
          cnt_q <= {CNT_W{1'b0}};
          dsr_q <= abs2_s;
          if (early_s) begin
            dvd_q <= {WIDTH{1'b0}};
            rem_q <= abs1_s;
          end else begin
            dvd_q <= abs1_s;
            rem_q <= {WIDTH{1'b0}};
          end
        end
        S_CALC: begin
          cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          if (!trial_s[WIDTH]) begin
            rem_q <= trial_s[WIDTH-1:0];
            dvd_q <= {dvd_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_q <= rem_sh_s[WIDTH-1:0];
            dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
          end
        end
        S_FIX: begin
          if (!cancel) begin
            result_q   <= result_d;
            div_zero_q <= div_zero_s;
          end else begin
            result_q <= result_q;
          end
        end
        S_DONE: begin
          result_q <= result_q;
        end
        default: begin
          result_q <= result_q;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign busy         = busy_q;
  assign out_valid    = out_valid_q;
  assign out_result   = result_q;
  assign out_div_zero = div_zero_q;

endmodule
